// File: rtl/rv32i_isa_enc_seq_if.sv
// Command and instruction-word stream bundle for the RV32I sequence encoder.
// master = command source / word consumer, slave = encoder.
interface rv32i_isa_enc_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [4:0]  cmd_rd;
    logic [31:0] cmd_val;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir;
    logic        ir_last;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_val, ir_ready,
        input  cmd_ready, ir_valid, ir, ir_last
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_val, ir_ready,
        output cmd_ready, ir_valid, ir, ir_last
    );
endinterface

// File: rtl/rv32i_isa_enc_seq.sv
// Expands LI / absolute-JUMP commands into LUI/ADDI/JALR sequences and emits
// them one word at a time on a valid/ready stream.
module rv32i_isa_enc_seq #(
    parameter bit SKIP_ZERO_ADDI = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rv32i_isa_enc_seq_if.slave     bus,
    output logic                   busy,
    output logic                   cmd_err
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    state_t      state, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] w2_q, w2_d;
    logic        last_q, last_d;
    logic        err_q, err_d;

    logic [11:0] lo;
    logic [31:0] rounded;
    logic [19:0] hi;
    logic        fits;
    logic [31:0] lui_w;
    logic [31:0] enc_w1, enc_w2;
    logic        enc_two, enc_illegal;

    // Encode the presented command; both words are captured at acceptance
    // instead of the raw fields, so later cmd_val changes cannot leak in.
    always_comb begin
        lo          = bus.cmd_val[11:0];
        rounded     = bus.cmd_val + 32'h0000_0800;
        hi          = rounded[31:12];
        fits        = (bus.cmd_val == {{20{lo[11]}}, lo});
        lui_w       = {hi, bus.cmd_rd, OP_LUI};
        enc_w1      = '0;
        enc_w2      = '0;
        enc_two     = 1'b0;
        enc_illegal = 1'b0;
        if (!bus.cmd_op) begin
            if (fits) begin
                enc_w1 = {lo, 5'd0, 3'b000, bus.cmd_rd, OP_ADDI};
            end else if (lo == 12'd0 && SKIP_ZERO_ADDI) begin
                enc_w1 = lui_w;
            end else begin
                enc_w1  = lui_w;
                enc_w2  = {lo, bus.cmd_rd, 3'b000, bus.cmd_rd, OP_ADDI};
                enc_two = 1'b1;
            end
        end else begin
            if (fits) begin
                enc_w1 = {lo, 5'd0, 3'b000, 5'd0, OP_JALR};
            end else if (bus.cmd_rd == 5'd0) begin
                enc_illegal = 1'b1;
            end else begin
                enc_w1  = lui_w;
                enc_w2  = {lo, bus.cmd_rd, 3'b000, 5'd0, OP_JALR};
                enc_two = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for the emit sequencer.
    always_comb begin
        state_d = state;
        ir_d    = ir_q;
        w2_d    = w2_q;
        last_d  = last_q;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = EMIT1;
                        ir_d    = enc_w1;
                        w2_d    = enc_w2;
                        last_d  = !enc_two;
                    end
                end
            end
            EMIT1: begin
                if (bus.ir_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        ir_d    = '0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = EMIT2;
                        ir_d    = w2_q;
                        last_d  = 1'b1;
                    end
                end
            end
            EMIT2: begin
                if (bus.ir_ready) begin
                    state_d = IDLE;
                    ir_d    = '0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ir_d    = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ir_q   <= '0;
            w2_q   <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            ir_q   <= ir_d;
            w2_q   <= w2_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    assign bus.cmd_ready = (state == IDLE);
    assign bus.ir_valid  = (state != IDLE);
    assign bus.ir        = ir_q;
    assign bus.ir_last   = last_q;
    assign busy          = (state != IDLE);
    assign cmd_err       = err_q;

endmodule

// File: doc/rv32i_isa_enc_seq.md
Name: rv32i_isa_enc_seq

Overview:
- Instruction-stream generator: the encode direction of the RV32I field decoder.
- Accepts high-level commands (load-immediate, absolute jump) and expands each into a legal RV32I instruction sequence (LUI/ADDI/JALR).
- Emits encoded 32-bit words one at a time on a valid/ready stream.
- Used by the debug program-buffer and boot-stub logic to inject instructions into the fetch path or instruction RAM.

Parameters:
SKIP_ZERO_ADDI, 1, when 1 an LI whose low 12 bits are zero emits LUI only; when 0 the trailing ADDI rd,rd,0 is always emitted.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted this cycle when cmd_valid & cmd_ready
cmd_op  input  1  0 = LI (load 32-bit constant into rd); 1 = JUMP (absolute jump via scratch rd)
cmd_rd  input  5  destination (LI) or scratch register (JUMP)
cmd_val  input  32  constant (LI) or absolute target address (JUMP)
ir_valid  output  1  encoded word valid
ir_ready  input  1  consumer accepts word when ir_valid & ir_ready
ir  output  32  encoded instruction word
ir_last  output  1  marks final word of the current command's sequence
busy  output  1  high whenever state != IDLE
cmd_err  output  1  one-cycle pulse on an illegal command

Behaviour:
- Reset (async assert, sync release): state = IDLE; ir_valid = 0, ir = 0, ir_last = 0, busy = 0, cmd_err = 0. cmd_ready = 1 in IDLE.
- cmd_ready = (state == IDLE). Command fields are latched on acceptance.
- Derived values, all arithmetic mod 2^32:
  - lo = val[11:0]
  - hi = (val + 32'h800)[31:12]
  - fits = (val == sign-extension of lo)
- Encodings:
  - LUI = {hi, rd, 7'b0110111}
  - ADDI = {imm12, rs1, 3'b000, rd, 7'b0010011}
  - JALR = {imm12, rs1, 3'b000, 5'd0, 7'b1100111}
- LI sequences:
  - fits: single ADDI rd,x0,lo.
  - lo == 0 and SKIP_ZERO_ADDI == 1: single LUI rd,hi.
  - otherwise: LUI rd,hi, then ADDI rd,rd,lo.
  - rd = 0 is legal and is encoded as-is.
- JUMP sequences:
  - fits: single JALR x0,x0,lo.
  - otherwise: LUI rd,hi, then JALR x0,rd,lo.
  - Not fitting with rd = 0: command accepted, no words emitted, cmd_err = 1 for exactly one cycle, state stays IDLE.
- States: IDLE -> EMIT1 -> (EMIT2 | IDLE); EMIT2 -> IDLE.
  - IDLE -> EMIT1: on accept of a legal command.
  - EMIT1 -> EMIT2: when the word is taken and it is not last.
  - EMIT1 -> IDLE: when the word is taken and it is last.
  - EMIT2 -> IDLE: when the word is taken.
- Output timing:
  - ir_valid is registered; first word appears the cycle after cmd acceptance (latency 1).
  - ir, ir_valid and ir_last are held stable while ir_valid & !ir_ready.
  - ir_valid never drops without a handshake.
  - The next word (or IDLE) takes effect the cycle after the handshake.
  - cmd_ready rises the cycle after the last word handshake, so there is one bubble between commands.
- cmd_val is ignored while busy; the latched copy alone drives encoding.
- Reset mid-sequence: the sequence is abandoned immediately; outputs return to reset values; no partial continuation after release.

Test Plan:
- LI rd=5, val=0x12345678 -> ir 0x123452B7 (last=0), then 0x67828293 (last=1); cmd_ready returns 1 the cycle after the second handshake.
- LI rd=1, val=0xFFFFF800 -> single word 0x80000093, last=1. LI rd=2, val=0x00001800 (negative-lo carry) -> 0x00002137, then 0x80010113.
- LI rd=3, val=0x00010000, SKIP_ZERO_ADDI=1 -> single 0x000101B7 with last=1; same command with SKIP_ZERO_ADDI=0 -> 0x000101B7, then 0x00018193.
- JUMP rd=6, val=0x80000004 -> 0x80000337, then 0x00430067 (last=1). JUMP rd=0, val=0x00001000 -> no ir_valid, cmd_err pulses one cycle, cmd_ready stays 1.
- Backpressure: hold ir_ready=0 for 3 cycles on each word of the LI x5 case -> ir/ir_last stable, cmd_ready=0 throughout, sequence unchanged.
- Boundary: LI rd=4, val=0x7FFFF900 -> LUI hi=0x80000 (0x80000237), ADDI lo=0x900 (0x90020213). Assert rst_n between the two words -> ir_valid=0 asynchronously, IDLE after release, no second word.
